// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequential unsigned shift-add multiplier sharing one CLA over N iterations.
// Optional EARLY_TERM_EN ends the run once the remaining multiplier bits are all zero.
module shift_add_mult_ctrl #(
  parameter int N = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     multiplicand,
  input  logic [N-1:0]     multiplier,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [N:0] a_q, a_d, add_sum, sum, a_n;
  logic [N-1:0] q_q, q_d, m_q, m_d, q_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0] product_q, product_d, fin;
  logic last;
`ifdef EARLY_TERM_EN
  logic [N-1:0] rem;
`endif
  cla #(.W(N + 1)) u_cla (.a(a_q), .b({1'b0, m_q}), .cin(1'b0), .sum(add_sum));
  always_comb begin
    sum = q_q[0] ? add_sum : a_q;
    a_n = {1'b0, sum[N:1]};
    q_n = {sum[0], q_q[N-1:1]};
`ifdef EARLY_TERM_EN
    // unconsumed multiplier bits sit at the bottom of Q; shifting the product bits out leaves only them
    rem = (q_q >> 1) << (cnt_q + 1'b1);
    last = rem == '0;
    fin = {a_n[N-1:0], q_n} >> (CNT_W'(N - 1) - cnt_q);
`else
    last = cnt_q == CNT_W'(N - 1);
    fin = {a_n[N-1:0], q_n};
`endif
    state_d = state_q;
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    cnt_d = cnt_q;
    product_d = product_q;
    if (state_q == RUN) begin
      a_d = a_n;
      q_d = q_n;
      cnt_d = cnt_q + 1'b1;
      state_d = last ? DONE : RUN;
      product_d = last ? fin : product_q;
    end else if (start) begin
      state_d = RUN;
      a_d = '0;
      q_d = multiplier;
      m_d = multiplicand;
      cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      product_q <= product_d;
    end
  end
  assign ready = state_q != RUN;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign product = product_q;
endmodule

// cla: flat two-level carry-lookahead adder, carry-out taken from the sum MSB by the caller.
module cla #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);
  logic [W-1:0] p, c;
  logic t, pp;
  always_comb begin
    p = a ^ b;
    c = '0;
    c[0] = cin;
    t = 1'b0;
    pp = 1'b1;
    for (int i = 1; i < W; i++) begin
      t = 1'b0;
      pp = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        t = t | (a[j] & b[j] & pp);
        pp = pp & p[j];
      end
      c[i] = t | (pp & cin);
    end
    sum = p ^ c;
  end
endmodule
